register_file: RTL
==================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data width of every register and of the ports I, OutA and OutB.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port I, input, WIDTH bits: write data, normally ALUOut of the downstream ALU or a memory/immediate source.
REQ-005 SHALL have port FunSel, input, 3 bits: operation applied to every enabled register.
REQ-006 SHALL have port RegSel, input, 4 bits: enables for general registers R1..R4 (bit3=R1, bit0=R4), active-high.
REQ-007 SHALL have port ScrSel, input, 4 bits: enables for scratch registers S1..S4 (bit3=S1, bit0=S4), active-high.
REQ-008 SHALL have port OutASel, input, 3 bits: source select for OutA, where 0-3 = R1-R4 and 4-7 = S1-S4.
REQ-009 SHALL have port OutBSel, input, 3 bits: source select for OutB, with the same encoding as OutASel.
REQ-010 SHALL have port OutA, output, WIDTH bits: read port A, feeding ALU input_a.
REQ-011 SHALL have port OutB, output, WIDTH bits: read port B, feeding ALU input_b.

Function
REQ-012 SHALL hold eight WIDTH-bit registers R1-R4 and S1-S4.
REQ-013 SHALL, on each rising clock edge, apply FunSel to every register whose RegSel/ScrSel bit is 1; registers with a 0 enable hold their value.
REQ-014 SHALL use the following FunSel encoding:
- 000: decrement by 1.
- 001: increment by 1.
- 010: load I.
- 011: clear to 0.
- 100: load I[7:0], clearing the upper bits.
- 101: load I[15:0], clearing the upper bits.
- 110: replace only bits [7:0] with I[7:0], keeping the upper bits.
- 111: load I[7:0] sign-extended to WIDTH.
REQ-015 SHALL make increment and decrement wrap modulo 2^WIDTH with no flag output: all-ones+1 -> 0, and 0-1 -> all-ones.
REQ-016 SHALL allow multiple enables in one cycle; each enabled register receives the same operation applied to its own old value.
REQ-017 SHALL drive OutA and OutB combinationally from the selected stored register, giving zero read latency.
REQ-018 SHALL let OutA and OutB select the same register simultaneously, both showing its value.
REQ-019 SHALL, when a register is read and written in the same cycle, show the pre-edge value on the read port and the new value from the cycle after the edge, unless REQ-024 applies.
REQ-020 SHALL treat an all-zero RegSel and ScrSel as a no-op cycle in which all registers hold.

Reset
REQ-021 SHALL clear all eight registers to 0 on a rising edge with reset=1, overriding FunSel and the enables.
REQ-022 SHALL make OutA and OutB read 0 in the cycle after reset for every select value.
REQ-023 SHALL discard any write requested in a reset cycle; reset asserted mid-sequence loses no state other than clearing it.

Configuration
REQ-024 SHALL, with macro REGISTER_FILE_BYPASS_EN defined, forward the next-state value of a register to OutA/OutB in the same cycle when that register is enabled, is selected, and reset=0; reads of non-enabled registers are unchanged.
REQ-025 SHALL, without REGISTER_FILE_BYPASS_EN, contain no forwarding logic, so read ports show stored values only, per REQ-019.

Verification
REQ-026 SHALL cover reset: reset=1 for one edge after arbitrary writes -> all eight registers read 0 through both ports.
REQ-027 SHALL cover load then increment: load R2=0x0000_00FF with FunSel=010 and RegSel=0100, then FunSel=001 -> OutASel=1 reads 0x0000_0100.
REQ-028 SHALL cover wrap: R1=0xFFFF_FFFF, then increment -> 0x0000_0000; then decrement -> 0xFFFF_FFFF.
REQ-029 SHALL cover byte ops: S3=0x1234_5678 with FunSel=110 and I=0xAB -> 0x1234_56AB; then FunSel=111 with I=0x80 -> 0xFFFF_FF80.
REQ-030 SHALL cover multi-write and dual read: RegSel=1111, ScrSel=1111, FunSel=010, I=0xCAFE_F00D -> all eight registers hold 0xCAFE_F00D; OutASel=0, OutBSel=7 both read it.
REQ-031 SHALL cover same-cycle read/write: R4=5, then in one cycle FunSel=001 with R4 selected on OutA -> OutA=5 in that cycle (6 with BYPASS_EN) and 6 in the next cycle.

Source files
------------

// File: rtl/register_file.sv
// Eight-entry register file (R1-R4, S1-S4) with per-register operations and two
// combinational read ports. Define REGISTER_FILE_BYPASS_EN to forward same-cycle writes.
module register_file #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [3:0]       RegSel,
  input  logic [3:0]       ScrSel,
  input  logic [2:0]       OutASel,
  input  logic [2:0]       OutBSel,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Entries 0-3 hold R1-R4, entries 4-7 hold S1-S4, matching the read-select encoding.
  logic [WIDTH-1:0] regs_reg  [8];
  logic [WIDTH-1:0] regs_next [8];
  logic [WIDTH-1:0] op_val    [8];
  logic [7:0]       en;

  // WIDTH must be at least 16 so the halfword load has room.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       fs,
    input logic [WIDTH-1:0] old_val,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] res;
    case (fs)
      3'b000:  res = old_val - ONE;
      3'b001:  res = old_val + ONE;
      3'b010:  res = din;
      3'b011:  res = '0;
      3'b100:  res = {{(WIDTH-8){1'b0}}, din[7:0]};
      3'b101:  res = {{(WIDTH-16){1'b0}}, din[15:0]};
      3'b110:  res = {old_val[WIDTH-1:8], din[7:0]};
      default: res = {{(WIDTH-8){din[7]}}, din[7:0]};
    endcase
    return res;
  endfunction

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_reg
      // Select bit 3 maps to the lowest-numbered register of each bank.
      if (gi < 4) begin : g_gen
        assign en[gi] = RegSel[3-gi];
      end else begin : g_scr
        assign en[gi] = ScrSel[7-gi];
      end
      assign op_val[gi]    = apply_op(FunSel, regs_reg[gi], I);
      assign regs_next[gi] = en[gi] ? op_val[gi] : regs_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock) begin
    for (int k = 0; k < 8; k++) begin
      if (reset) begin
        regs_reg[k] <= '0;
      end else begin
        regs_reg[k] <= regs_next[k];
      end
    end
  end

`ifdef REGISTER_FILE_BYPASS_EN
  // Forward the value about to be written so readers see it without waiting an edge.
  assign OutA = (en[OutASel] && !reset) ? op_val[OutASel] : regs_reg[OutASel];
  assign OutB = (en[OutBSel] && !reset) ? op_val[OutBSel] : regs_reg[OutBSel];
`else
  assign OutA = regs_reg[OutASel];
  assign OutB = regs_reg[OutBSel];
`endif

endmodule
